// File: rtl/grill_slot_manager.sv
// Four-slot grill: spawns steaks on show requests, ages them on a one-second
// prescaler tick, and classifies player picks into good/bad counts and a score.
`timescale 1ns/1ps

module grill_slot_manager #(
  parameter int unsigned CLKS_PER_SEC = 50_000_000,
  parameter int unsigned DONE_SEC     = 5,
  parameter int unsigned BURN_SEC     = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       steak_show,
  input  logic [3:0] pick,
  output logic [7:0] slot_state,
  output logic       spawn_drop,
  output logic [2:0] good_n,
  output logic [2:0] bad_n,
  output logic [7:0] score
);

  localparam int unsigned NSLOT   = 4;
  localparam int unsigned AGE_W   = 4;
  localparam int unsigned CNT_W   = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int unsigned CNT_W_N = 3;
  localparam int unsigned SCORE_W = 8;

  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(CLKS_PER_SEC - 1);
  localparam logic [AGE_W-1:0]   AGE_MAX  = AGE_W'(15);
  localparam logic [AGE_W-1:0]   DONE_AGE = AGE_W'(DONE_SEC);
  localparam logic [AGE_W-1:0]   BURN_AGE = AGE_W'(BURN_SEC);
  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(255);

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_COOKING = 2'b01,
    ST_DONE    = 2'b10,
    ST_BURNT   = 2'b11
  } slot_st_e;

  slot_st_e             st_q   [NSLOT];
  slot_st_e             st_d   [NSLOT];
  logic [AGE_W-1:0]     age_q  [NSLOT];
  logic [AGE_W-1:0]     age_d  [NSLOT];
  logic [AGE_W-1:0]     age_inc_c [NSLOT];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 drop_q, drop_d;
  logic [CNT_W_N-1:0]   good_q, good_d;
  logic [CNT_W_N-1:0]   bad_q, bad_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W:0]     score_sum_c;
  logic                 sec_tick_c;
  logic [NSLOT-1:0]     empty_c;
  logic [NSLOT-1:0]     spawn_oh_c;

  // One-second prescaler; wraps to 0 in the cycle after its maximum.
  assign sec_tick_c = (cnt_q == CNT_MAX);
  assign cnt_d      = sec_tick_c ? '0 : cnt_q + CNT_W'(1);

  // Allocation looks at occupancy at the start of the cycle only.
  always_comb begin
    empty_c = '0;
    for (int i = 0; i < NSLOT; i++) begin
      empty_c[i] = (st_q[i] == ST_EMPTY);
      age_inc_c[i] = (age_q[i] == AGE_MAX) ? AGE_MAX : age_q[i] + AGE_W'(1);
    end
    spawn_oh_c = NSLOT'(empty_c & (~empty_c + NSLOT'(1)));
  end

  // Per-slot next state: pick beats aging; spawn only lands on a start-of-cycle empty slot.
  always_comb begin
    good_d = '0;
    bad_d  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      st_d[i]  = st_q[i];
      age_d[i] = age_q[i];
      if (pick[i] && (st_q[i] != ST_EMPTY)) begin
        if (st_q[i] == ST_DONE) begin
          good_d = good_d + CNT_W_N'(1);
        end else begin
          bad_d = bad_d + CNT_W_N'(1);
        end
        st_d[i]  = ST_EMPTY;
        age_d[i] = '0;
      end else if ((st_q[i] != ST_EMPTY) && sec_tick_c) begin
        age_d[i] = age_inc_c[i];
        case (st_q[i])
          ST_COOKING: if (age_inc_c[i] == DONE_AGE) st_d[i] = ST_DONE;
          ST_DONE:    if (age_inc_c[i] == BURN_AGE) st_d[i] = ST_BURNT;
          default:    ;
        endcase
      end else if (steak_show && spawn_oh_c[i]) begin
        st_d[i]  = ST_COOKING;
        age_d[i] = '0;
      end
    end
  end

  assign drop_d = steak_show && (empty_c == '0);

  // Score accumulates the previous cycle's good count, saturating.
  always_comb begin
    score_sum_c = {1'b0, score_q} + (SCORE_W + 1)'(good_q);
    score_d     = score_sum_c[SCORE_W] ? SCORE_MAX : score_sum_c[SCORE_W-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      drop_q  <= 1'b0;
      good_q  <= '0;
      bad_q   <= '0;
      score_q <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        st_q[i]  <= ST_EMPTY;
        age_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      score_q <= score_d;
      for (int i = 0; i < NSLOT; i++) begin
        st_q[i]  <= st_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  always_comb begin
    slot_state = '0;
    for (int i = 0; i < NSLOT; i++) begin
      slot_state[2*i +: 2] = st_q[i];
    end
  end

  assign spawn_drop = drop_q;
  assign good_n     = good_q;
  assign bad_n      = bad_q;
  assign score      = score_q;

endmodule

// File: tb/tb_grill_slot_manager.sv
// Bench for grill_slot_manager: directed scenarios plus random traffic, all
// checked every cycle against an array-based model of the grill.
`timescale 1ns/1ps

module tb_grill_slot_manager;

  localparam int CPS  = 10;
  localparam int DONE = 2;
  localparam int BURN = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       steak_show;
  logic [3:0] pick;
  logic [7:0] slot_state;
  logic       spawn_drop;
  logic [2:0] good_n;
  logic [2:0] bad_n;
  logic [7:0] score;

  int n_total = 0;
  int n_bad   = 0;

  // Model: slot state as 0 empty, 1 cooking, 2 done, 3 burnt.
  int m_st  [4];
  int m_age [4];
  int m_pre, m_good, m_bad, m_score, m_drop;

  grill_slot_manager #(
    .CLKS_PER_SEC(CPS),
    .DONE_SEC    (DONE),
    .BURN_SEC    (BURN)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .steak_show (steak_show),
    .pick       (pick),
    .slot_state (slot_state),
    .spawn_drop (spawn_drop),
    .good_n     (good_n),
    .bad_n      (bad_n),
    .score      (score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i]  = 0;
      m_age[i] = 0;
    end
    m_pre = 0; m_good = 0; m_bad = 0; m_score = 0; m_drop = 0;
  endtask

  task automatic model_step(input bit show, input logic [3:0] pk);
    int nst [4];
    int nage[4];
    int g, b, sp;
    bit tick;
    g = 0; b = 0; sp = -1;
    tick = (m_pre == CPS - 1);
    for (int i = 0; i < 4; i++) begin
      nst[i]  = m_st[i];
      nage[i] = m_age[i];
      if (pk[i] && m_st[i] != 0) begin
        if (m_st[i] == 2) g++; else b++;
        nst[i] = 0; nage[i] = 0;
      end else if (m_st[i] != 0 && tick) begin
        nage[i] = (m_age[i] + 1 > 15) ? 15 : m_age[i] + 1;
        if (m_st[i] == 1 && nage[i] == DONE) nst[i] = 2;
        else if (m_st[i] == 2 && nage[i] == BURN) nst[i] = 3;
      end
    end
    if (show) begin
      for (int i = 3; i >= 0; i--) if (m_st[i] == 0) sp = i;
      if (sp >= 0) begin
        nst[sp] = 1; nage[sp] = 0;
      end
    end
    m_drop  = (show && sp < 0) ? 1 : 0;
    m_score = (m_score + m_good > 255) ? 255 : m_score + m_good;
    m_good  = g;
    m_bad   = b;
    m_pre   = tick ? 0 : m_pre + 1;
    for (int i = 0; i < 4; i++) begin
      m_st[i]  = nst[i];
      m_age[i] = nage[i];
    end
  endtask

  function automatic int model_slots();
    int v = 0;
    for (int i = 0; i < 4; i++) v += m_st[i] << (2 * i);
    return v;
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("slot_state", int'(slot_state), model_slots());
    chk("spawn_drop", int'(spawn_drop), m_drop);
    chk("good_n", int'(good_n), m_good);
    chk("bad_n", int'(bad_n), m_bad);
    chk("score", int'(score), m_score);
  end

  task automatic cycle(input bit show, input logic [3:0] pk);
    steak_show = show;
    pick       = pk;
    @(posedge clk);
    model_step(show, pk);
    #1;
    steak_show = 1'b0;
    pick       = 4'd0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic wait_field(input logic [7:0] mask, input logic [7:0] want,
                            input int max_cyc, input string name);
    bit found = 1'b0;
    for (int k = 0; k < max_cyc && !found; k++) begin
      cycle(1'b0, 4'd0);
      if ((slot_state & mask) == want) found = 1'b1;
    end
    chk(name, int'(found), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    steak_show = 1'b0;
    pick       = 4'd0;
    model_reset();
    #1;
    do_reset();
    chk("rst_slots", int'(slot_state), 0);
    chk("rst_score", int'(score), 0);

    // Single steak lifecycle with a tick every 10 edges.
    cycle(1'b1, 4'd0);
    chk("spawn0", int'(slot_state), 8'h01);
    repeat (18) cycle(1'b0, 4'd0);
    chk("before_done", int'(slot_state), 8'h01);
    cycle(1'b0, 4'd0);
    chk("done_at_tick2", int'(slot_state), 8'h02);
    repeat (19) cycle(1'b0, 4'd0);
    chk("before_burn", int'(slot_state), 8'h02);
    cycle(1'b0, 4'd0);
    chk("burnt_at_tick4", int'(slot_state), 8'h03);
    repeat (200) cycle(1'b0, 4'd0);
    chk("burnt_stays", int'(slot_state), 8'h03);

    // Fill order and drop on a full grill.
    do_reset();
    cycle(1'b1, 4'd0); chk("fill1", int'(slot_state), 8'h01); repeat (2) cycle(1'b0, 4'd0);
    cycle(1'b1, 4'd0); chk("fill2", int'(slot_state), 8'h05); repeat (2) cycle(1'b0, 4'd0);
    cycle(1'b1, 4'd0); chk("fill3", int'(slot_state), 8'h15); repeat (2) cycle(1'b0, 4'd0);
    cycle(1'b1, 4'd0); chk("fill4", int'(slot_state), 8'h55); repeat (2) cycle(1'b0, 4'd0);
    cycle(1'b1, 4'd0);
    chk("fill5_state", int'(slot_state), 8'h55);
    chk("fill5_drop", int'(spawn_drop), 1);
    cycle(1'b0, 4'd0);
    chk("drop_clears", int'(spawn_drop), 0);

    // Mixed good and bad pick in one cycle.
    do_reset();
    repeat (3) cycle(1'b1, 4'd0);
    wait_field(8'hFF, 8'h3F, 60, "wait_all_burnt");
    cycle(1'b0, 4'b0010);
    chk("pick_burnt_bad", int'(bad_n), 1);
    chk("pick_burnt_state", int'(slot_state), 8'h33);
    cycle(1'b1, 4'd0);
    chk("respawn_slot1", int'(slot_state), 8'h37);
    wait_field(8'h0C, 8'h08, 40, "wait_slot1_done");
    chk("mix_before", int'(slot_state), 8'h3B);
    cycle(1'b0, 4'b0110);
    chk("mix_good", int'(good_n), 1);
    chk("mix_bad", int'(bad_n), 1);
    chk("mix_state", int'(slot_state), 8'h03);
    chk("mix_score_lag", int'(score), 0);
    cycle(1'b0, 4'd0);
    chk("mix_score", int'(score), 1);
    chk("mix_good_clear", int'(good_n), 0);
    cycle(1'b0, 4'b0010);
    chk("empty_pick_good", int'(good_n), 0);
    chk("empty_pick_bad", int'(bad_n), 0);

    // Pick and spawn together on a full grill.
    repeat (3) cycle(1'b1, 4'd0);
    chk("full_state", int'(slot_state), 8'h57);
    cycle(1'b1, 4'b0001);
    chk("pick_spawn_drop", int'(spawn_drop), 1);
    chk("pick_spawn_state", int'(slot_state), 8'h54);
    cycle(1'b1, 4'd0);
    chk("refill_drop", int'(spawn_drop), 0);
    chk("refill_state", int'(slot_state), 8'h55);

    // Random traffic.
    for (int k = 0; k < 1500; k++) begin
      logic [3:0] pk;
      for (int b = 0; b < 4; b++) pk[b] = ($urandom_range(7) == 0);
      cycle(($urandom_range(3) == 0), pk);
    end

    // Score saturation with rounds of four DONE picks.
    do_reset();
    for (int r = 0; r < 65; r++) begin
      repeat (4) cycle(1'b1, 4'd0);
      wait_field(8'hFF, 8'hAA, 50, "wait_all_done");
      cycle(1'b0, 4'hF);
    end
    chk("last_round_good", int'(good_n), 4);
    repeat (2) cycle(1'b0, 4'd0);
    chk("score_sat", int'(score), 255);

    // Asynchronous reset in the middle of a cycle while cooking.
    repeat (2) cycle(1'b1, 4'd0);
    repeat (15) cycle(1'b0, 4'd0);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    chk("async_slots", int'(slot_state), 0);
    chk("async_score", int'(score), 0);
    chk("async_good", int'(good_n), 0);
    chk("async_bad", int'(bad_n), 0);
    chk("async_drop", int'(spawn_drop), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Spawn exactly on the tick edge: prescaler restarted from 0.
    repeat (9) cycle(1'b0, 4'd0);
    cycle(1'b1, 4'd0);
    chk("tick_spawn", int'(slot_state), 8'h01);
    repeat (10) cycle(1'b0, 4'd0);
    chk("tick_spawn_1s", int'(slot_state), 8'h01);
    repeat (10) cycle(1'b0, 4'd0);
    chk("tick_spawn_2s", int'(slot_state), 8'h02);

    repeat (2) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/grill_slot_manager.md
# grill_slot_manager

Downstream consumer of the steak-show pulse. Each one-cycle `steak_show` request places a raw steak on the lowest-numbered free slot of a four-slot grill. The block ages every occupied slot in whole seconds and advances it through cooking, done and burnt. It resolves player picks into good/bad results and a running score for the display and score logic.

## Interface
- `CLKS_PER_SEC`, default 50_000_000: clock cycles per one-second tick.
- `DONE_SEC`, default 5: age in seconds at which a slot becomes DONE.
- `BURN_SEC`, default 8: age in seconds at which a slot becomes BURNT. Requires 1 <= DONE_SEC < BURN_SEC <= 15.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `steak_show`  in  1  one-cycle spawn request from the show counter.
- `pick`  in  4  per-slot player pick strobes, one cycle each; bit i = slot i.
- `slot_state`  out  8  two bits per slot, slot i at [2i+1:2i]: 00 EMPTY, 01 COOKING, 10 DONE, 11 BURNT.
- `spawn_drop`  out  1  one-cycle pulse: spawn request arrived with all slots occupied.
- `good_n`  out  3  number of DONE steaks picked in the previous cycle (0–4).
- `bad_n`  out  3  number of COOKING or BURNT steaks picked in the previous cycle (0–4).
- `score`  out  8  running count of good picks, saturating at 255.

## Operation
- Prescaler: free-running counter 0..CLKS_PER_SEC-1. `sec_tick` is high for one cycle when the counter is at its maximum, then the counter wraps to 0. The prescaler is global, so a spawned steak's first second is partial: 0 to 1 s.
- Per-slot state: 2-bit state plus 4-bit age, in seconds, saturating at 15.
- Spawn: on `steak_show`, the lowest-index EMPTY slot becomes COOKING with age 0.
  - Exactly one slot is filled per request.
  - With no EMPTY slot, no slot changes and `spawn_drop` pulses.
- Aging: on `sec_tick`, every non-EMPTY slot increments its age, saturating at 15.
  - COOKING→DONE when the new age equals DONE_SEC.
  - DONE→BURNT when the new age equals BURN_SEC.
  - BURNT stays BURNT until picked.
- Pick: `pick[i]` on an EMPTY slot is ignored. On a non-EMPTY slot, the slot becomes EMPTY with age 0 and the result is classified:
  - DONE counts as good.
  - COOKING or BURNT counts as bad.
- Several picks in one cycle are all processed. `good_n` and `bad_n` are the popcounts of the classified picks.
- `score` adds `good_n` each cycle and saturates at 255; bad picks never subtract.
- Simultaneous events, all in one cycle:
  - Spawn and pick: allocation uses occupancy at the start of the cycle, so a slot freed by a pick is not refilled that cycle.
  - Spawn and tick: the newly spawned slot is not aged that cycle.
  - Pick and tick on the same slot: the pick wins and is classified on the pre-tick state.
- Reset, asserted at any time including mid-cook:
  - all slots EMPTY with age 0
  - prescaler 0
  - `score`, `good_n`, `bad_n` and `spawn_drop` all 0
  - `slot_state` = 8'h00

## Timing
- All outputs are registered. Reset values are as listed above.
- `steak_show` sampled at edge N → `slot_state` shows COOKING after edge N, or `spawn_drop` is high for the cycle after edge N.
- `pick` sampled at edge N → slot EMPTY and `good_n`/`bad_n` valid for exactly one cycle after edge N. `score` reflects the pick one cycle later still, after edge N+1.
- State transitions appear one cycle after the `sec_tick` cycle.
- `spawn_drop`, `good_n` and `bad_n` return to 0 after one cycle unless re-triggered.
- There is no handshake back to the show counter; a dropped request is lost.

## Test plan
Run with CLKS_PER_SEC=10, DONE_SEC=2, BURN_SEC=4.

- Reset, then one `steak_show` → `slot_state` = 8'h01. Slot 0 reaches DONE (8'h02) after the 2nd tick and BURNT (8'h03) after the 4th tick. It is still 8'h03 after 20 further ticks.
- Five `steak_show` pulses 3 cycles apart → `slot_state` low bits fill in order 01, 05, 15, 55. The fifth pulse gives a one-cycle `spawn_drop`=1 and no state change.
- Slot 1 DONE and slot 2 BURNT, then `pick`=4'b0110 in one cycle → the next cycle shows `good_n`=1, `bad_n`=1, slots 1 and 2 EMPTY. `score` increments by 1 one cycle later. A pick on an EMPTY slot gives 0/0.
- All slots full. Assert `pick`=4'b0001 and `steak_show` in the same cycle → slot 0 EMPTY and `spawn_drop`=1. A second `steak_show` next cycle fills slot 0 with COOKING.
- Spawn on the exact `sec_tick` cycle → the slot's age is 0 after the tick. DONE is reached after 2 further ticks, not 1.
- 260 good picks → `score` saturates at 255. Assert `resetn` low mid-cook → all outputs 0 immediately and asynchronously. The prescaler restarts from 0 after release.
